multiword_add_seq: RTL and testbench

//   Sequences one shared 8-bit carry-lookahead adder slice over multi-byte operands.

---
 rtl/multiword_add_seq_pkg.sv | 13 +
 rtl/multiword_add_seq_cla8_unit.sv | 45 ++++
 rtl/multiword_add_seq.sv | 158 +++++++++++++++
 tb/tb_multiword_add_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the byte-serial multi-word adder: slice width and
// controller state encoding.
package multiword_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiword_add_seq_cla8_unit.sv
// Combinational 8-bit carry-lookahead adder slice. Each carry is built directly
// from generate/propagate terms and cin rather than rippled from its neighbour.
module cla8_unit
    import multiword_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    logic [BYTE_W-1:0] g_s;
    logic [BYTE_W-1:0] p_s;
    logic [BYTE_W:0]   c_s;
    logic              term_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Lookahead carries: c[i] = OR over j<i of (g[j] & p[j+1..i-1]) | (cin & p[0..i-1])
    always_comb begin
        c_s    = '0;
        term_s = 1'b0;
        c_s[0] = cin;
        for (int i = 1; i <= BYTE_W; i++) begin
            for (int j = 0; j < i; j++) begin
                term_s = g_s[j];
                for (int k = j + 1; k < i; k++) begin
                    term_s = term_s & p_s[k];
                end
                c_s[i] = c_s[i] | term_s;
            end
            term_s = cin;
            for (int k = 0; k < i; k++) begin
                term_s = term_s & p_s[k];
            end
            c_s[i] = c_s[i] | term_s;
        end
    end

    assign s    = p_s ^ c_s[BYTE_W-1:0];
    assign cout = c_s[BYTE_W];

endmodule

// File: rtl/multiword_add_seq.sv
// Byte-serial add/subtract of two WORDS-byte operands through one shared CLA
// slice, LSB byte first, with a registered carry chained between bytes.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BYTE_W*WORDS-1:0]   a,
    input  logic [BYTE_W*WORDS-1:0]   b,
    input  logic                      sub,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BYTE_W*WORDS-1:0]   result,
    output logic                      cout,
    output logic                      ovf,
    output logic                      zero
);

    localparam int W     = BYTE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [IDX_W-1:0]  idx_r;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic [W-1:0]      result_r;
    logic [W-1:0]      result_next_s;
    logic              carry_r;
    logic              cout_r;
    logic              ovf_r;
    logic              zero_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic              accept_s;
    logic              step_s;
    logic              release_s;
    logic              last_s;
    logic [BYTE_W-1:0] sum_s;
    logic              c_s;

    cla8_unit u_cla8 (
        .a    (a_r[BYTE_W-1:0]),
        .b    (b_r[BYTE_W-1:0]),
        .cin  (carry_r),
        .s    (sum_s),
        .cout (c_s)
    );

    assign last_s = (idx_r == LAST_IDX);

    // Each new byte enters at the top so byte 0 lands at the bottom after WORDS steps.
    generate
        if (WORDS == 1) begin : g_res_one
            assign result_next_s = sum_s;
        end else begin : g_res_many
            assign result_next_s = {sum_s, result_r[W-1:BYTE_W]};
        end
    endgenerate

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Controller next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_next_s = ST_RUN;
                else          state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_next_s = ST_DONE;
                else        state_next_s = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) state_next_s = ST_IDLE;
                else           state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Controller datapath strobes
    always_comb begin
        accept_s  = 1'b0;
        step_s    = 1'b0;
        release_s = 1'b0;
        case (state_r)
            ST_IDLE: accept_s  = in_valid;
            ST_RUN:  step_s    = 1'b1;
            ST_DONE: release_s = out_ready;
            default: begin
                accept_s  = 1'b0;
                step_s    = 1'b0;
                release_s = 1'b0;
            end
        endcase
    end

    // Operand shift registers, carry chain, result capture and handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            result_r    <= '0;
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (accept_s) begin
            a_r        <= a;
            b_r        <= sub ? ~b : b;
            carry_r    <= sub ? 1'b1 : cin;
            idx_r      <= '0;
            in_ready_r <= 1'b0;
        end else if (step_s) begin
            a_r      <= a_r >> BYTE_W;
            b_r      <= b_r >> BYTE_W;
            carry_r  <= c_s;
            result_r <= result_next_s;
            if (last_s) begin
                cout_r      <= c_s;
                ovf_r       <= (a_r[BYTE_W-1] ^ b_r[BYTE_W-1] ^ sum_s[BYTE_W-1]) ^ c_s;
                zero_r      <= ~|result_next_s;
                out_valid_r <= 1'b1;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else if (release_s) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (WORDS=4): vector table, random
// operations against a 33-bit arithmetic model, stall and mid-run reset.
module tb_multiword_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        exp_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[8];

    multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic ms, input logic mc);
        exp_t        e;
        logic [W:0]  full;
        if (ms) begin
            full = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
            e.ov = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
            e.ov = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
        end
        e.res = full[W-1:0];
        e.co  = full[W];
        e.z   = (full[W-1:0] == 32'd0);
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic tc, input exp_t e, input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    endtask

    task automatic collect(input int stall, input string nm);
        int   cnt;
        exp_t e;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (out_valid || cnt >= 20) break;
            @(posedge clk);
            cnt++;
        end
        chk({nm, "_latency"}, cnt, WORDS);
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s_scoreboard: got output expected none", nm);
            end else begin
                e = sb.pop_front();
                for (int k = 0; k <= stall; k++) begin
                    chk({nm, "_result"}, result, e.res);
                    chk({nm, "_cout"}, {31'd0, cout}, {31'd0, e.co});
                    chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, e.ov});
                    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, e.z});
                    if (k < stall) begin
                        chk({nm, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
                        chk({nm, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
                        in_valid = k[0] ? 1'b0 : 1'b1;
                        a = $urandom; b = $urandom;
                        @(negedge clk);
                    end
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk({nm, "_ready_after"}, {31'd0, in_ready}, 32'd1);
                chk({nm, "_valid_after"}, {31'd0, out_valid}, 32'd0);
            end
        end
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic tc, input exp_t e, input string nm);
        issue(ta, tb_, ts, tc, e, nm);
        collect(0, nm);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs, rc;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
        vecs[5] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, '{32'hACF13568, 1'b0, 1'b0, 1'b0}};
        vecs[6] = '{32'h55AA55AA, 32'h55AA55AA, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, '{32'h00000001, 1'b1, 1'b1, 1'b0}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'd0; b = 32'd0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {29'd0, cout, ovf, zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, vecs[i].e,
                  $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
            do_op(ra, rb, rs, rc, model(ra, rb, rs, rc), $sformatf("rand%0d", i));
        end

        // Consumer stalls five cycles in DONE while the requester keeps pulsing.
        issue(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1, model(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1), "stall");
        collect(5, "stall");
        repeat (2) @(negedge clk);
        chk("stall_no_second", {31'd0, out_valid}, 32'd0);

        // Reset while RUN is working on byte 2; the operation is lost.
        issue(32'h11111111, 32'h22222222, 1'b0, 1'b0, model(32'h11111111, 32'h22222222, 1'b0, 1'b0), "rst");
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("midrun_rst_no_output", {31'd0, out_valid}, 32'd0);
        end
        do_op(32'd1, 32'd2, 1'b0, 1'b0, '{32'd3, 1'b0, 1'b0, 1'b0}, "after_rst");

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
